vend_fsm_param: RTL and testbench

- Parametrised vending-machine controller: accumulates coin credit, advertises affordable drinks, vends one selection, returns change.
- Successor to the fixed four-drink controller:
  - drink count, price ladder and credit width are parameters;
  - the affordability display becomes a registered `avail` mask;
  - adds explicit coin/selection strobes, over-limit coin rejection, cancel refund and a synchronous single-clock FSM.

---
 rtl/vend_fsm_param.sv | 141 ++++++++++++++
 tb/tb_vend_fsm_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: coin credit, affordability mask, single vend, change refund.
// Optional VEND_KEEP_CREDIT_EN: leftover credit after a vend is retained instead of refunded.
module vend_fsm_param #(
  parameter int CREDIT_W   = 8,
  parameter int NUM_DRINKS = 4,
  parameter int SEL_W      = 3,
  parameter int BASE_PRICE = 10,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  coin_valid,
  input  logic [CREDIT_W-1:0]   coin,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      drink_choose,
  input  logic                  cancel,
  output logic [CREDIT_W-1:0]   total_coin,
  output logic [NUM_DRINKS-1:0] avail,
  output logic [NUM_DRINKS-1:0] dispense,
  output logic                  dispense_valid,
  output logic [CREDIT_W-1:0]   change,
  output logic                  change_valid,
  output logic                  coin_reject,
  output logic                  sel_reject,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_e;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [NUM_DRINKS-1:0] dispense_q, dispense_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  sel_reject_q, sel_reject_d;

  logic [CREDIT_W:0]     sum;
  logic                  sel_hit;
  logic [NUM_DRINKS-1:0] sel_onehot;
  logic [CREDIT_W-1:0]   sel_price;

  function automatic logic [31:0] price(input int k);
    return 32'(BASE_PRICE + (k - 1) * PRICE_STEP);
  endfunction

  always_comb begin
    avail = '0;
    for (int k = 1; k <= NUM_DRINKS; k++) begin
      avail[k-1] = (32'(credit_q) >= price(k));
    end
  end

  // Decode the selection against the price ladder; out-of-range indices never hit.
  always_comb begin
    sel_hit    = 1'b0;
    sel_onehot = '0;
    sel_price  = '0;
    for (int k = 1; k <= NUM_DRINKS; k++) begin
      if (drink_choose == SEL_W'(k)) begin
        sel_hit         = avail[k-1];
        sel_onehot[k-1] = 1'b1;
        sel_price       = CREDIT_W'(price(k));
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    dispense_d    = '0;
    coin_reject_d = 1'b0;
    sel_reject_d  = 1'b0;
    sum           = {1'b0, credit_q} + {1'b0, coin};
    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          if (credit_q != '0) state_d = S_CHANGE;
        end else if (coin_valid) begin
          if (sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = sum[CREDIT_W-1:0];
            if (sum != '0) state_d = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (sel_valid) begin
          if (sel_hit) begin
            credit_d   = credit_q - sel_price;
            dispense_d = sel_onehot;
            state_d    = S_VEND;
          end else begin
            sel_reject_d = 1'b1;
          end
        end
      end
      // Credit here already holds the remainder latched at selection time.
      S_VEND: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
`ifdef VEND_KEEP_CREDIT_EN
          state_d = S_CREDIT;
`else
          state_d = S_CHANGE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      dispense_q    <= '0;
      coin_reject_q <= 1'b0;
      sel_reject_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      dispense_q    <= dispense_d;
      coin_reject_q <= coin_reject_d;
      sel_reject_q  <= sel_reject_d;
    end
  end

  assign total_coin     = credit_q;
  assign dispense       = dispense_q;
  assign dispense_valid = (state_q == S_VEND);
  assign change_valid   = (state_q == S_CHANGE);
  assign change         = (state_q == S_CHANGE) ? credit_q : '0;
  assign coin_reject    = coin_reject_q;
  assign sel_reject     = sel_reject_q;
  assign busy           = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param at default parameters (prices 10,15,20,25; max credit 100).
module tb_vend_fsm_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [7:0] coin;
  logic       sel_valid;
  logic [2:0] drink_choose;
  logic       cancel;
  logic [7:0] total_coin;
  logic [3:0] avail;
  logic [3:0] dispense;
  logic       dispense_valid;
  logic [7:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       sel_reject;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  vend_fsm_param dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .drink_choose(drink_choose),
    .cancel(cancel),
    .total_coin(total_coin), .avail(avail),
    .dispense(dispense), .dispense_valid(dispense_valid),
    .change(change), .change_valid(change_valid),
    .coin_reject(coin_reject), .sel_reject(sel_reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of strobes, let the edge take them, then clear them.
  task automatic applyStimulus(input logic cv, input logic [7:0] c,
                               input logic sv, input logic [2:0] s,
                               input logic cn);
    coin_valid   = cv;
    coin         = c;
    sel_valid    = sv;
    drink_choose = s;
    cancel       = cn;
    tick();
    coin_valid   = 1'b0;
    coin         = '0;
    sel_valid    = 1'b0;
    drink_choose = '0;
    cancel       = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    coin_valid = 1'b0; coin = '0; sel_valid = 1'b0; drink_choose = '0; cancel = 1'b0;
    tick(); tick();
    checkOutput("rst_total", 32'(total_coin), 0);
    checkOutput("rst_avail", 32'(avail), 0);
    checkOutput("rst_flags", {busy, dispense_valid, change_valid, coin_reject, sel_reject}, 0);
    checkOutput("rst_dispense", 32'(dispense), 0);
    reset = 1'b1;
    tick();

    // Coin accumulation
    applyStimulus(1, 8'd5, 0, 0, 0);
    checkOutput("acc_5", 32'(total_coin), 5);
    applyStimulus(1, 8'd5, 0, 0, 0);
    checkOutput("acc_10", 32'(total_coin), 10);
    applyStimulus(1, 8'd10, 0, 0, 0);
    checkOutput("acc_20", 32'(total_coin), 20);
    checkOutput("acc_avail", 32'(avail), 32'h7);

    // Purchase drink 2 with change
    applyStimulus(0, 0, 1, 3'd2, 0);
    checkOutput("buy_dv", 32'(dispense_valid), 1);
    checkOutput("buy_disp", 32'(dispense), 32'h2);
    checkOutput("buy_total", 32'(total_coin), 5);
    checkOutput("buy_busy", 32'(busy), 1);
    tick();
    checkOutput("buy_cv", 32'(change_valid), 1);
    checkOutput("buy_change", 32'(change), 5);
    checkOutput("buy_dv_off", 32'(dispense_valid), 0);
    tick();
    checkOutput("buy_idle_total", 32'(total_coin), 0);
    checkOutput("buy_idle_flags", {busy, change_valid}, 0);

    // Selection rejects at credit 10
    applyStimulus(1, 8'd10, 0, 0, 0);
    applyStimulus(0, 0, 1, 3'd3, 0);
    checkOutput("rej3_pulse", 32'(sel_reject), 1);
    checkOutput("rej3_total", 32'(total_coin), 10);
    checkOutput("rej3_dv", 32'(dispense_valid), 0);
    tick();
    checkOutput("rej_pulse_end", 32'(sel_reject), 0);
    applyStimulus(0, 0, 1, 3'd0, 0);
    checkOutput("rej0_pulse", 32'(sel_reject), 1);
    applyStimulus(0, 0, 1, 3'd5, 0);
    checkOutput("rej5_pulse", 32'(sel_reject), 1);
    checkOutput("rej5_total", 32'(total_coin), 10);

    // Coin limit
    applyStimulus(1, 8'd85, 0, 0, 0);
    checkOutput("lim_95", 32'(total_coin), 95);
    applyStimulus(1, 8'd10, 0, 0, 0);
    checkOutput("lim_reject", 32'(coin_reject), 1);
    checkOutput("lim_keep", 32'(total_coin), 95);
    applyStimulus(1, 8'd5, 0, 0, 0);
    checkOutput("lim_100", 32'(total_coin), 100);
    checkOutput("lim_noreject", 32'(coin_reject), 0);
    checkOutput("lim_avail", 32'(avail), 32'hF);
    applyStimulus(1, 8'd0, 1, 3'd1, 0);
    checkOutput("coinsel_total", 32'(total_coin), 100);
    checkOutput("coinsel_flags", {dispense_valid, sel_reject, coin_reject}, 0);

    // Cancel at 100, then at 30 with a dropped coin, then at zero
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("can100_cv", 32'(change_valid), 1);
    checkOutput("can100_change", 32'(change), 100);
    tick();
    checkOutput("can100_total", 32'(total_coin), 0);
    applyStimulus(1, 8'd30, 0, 0, 0);
    applyStimulus(1, 8'd5, 0, 0, 1);
    checkOutput("can30_change", 32'(change), 30);
    checkOutput("can30_cv", 32'(change_valid), 1);
    checkOutput("can30_noreject", 32'(coin_reject), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("can0_flags", {change_valid, busy, coin_reject}, 0);
    checkOutput("can0_total", 32'(total_coin), 0);

    // Coin during VEND is rejected and not credited
    applyStimulus(1, 8'd20, 0, 0, 0);
    applyStimulus(0, 0, 1, 3'd1, 0);
    checkOutput("vcoin_dv", 32'(dispense_valid), 1);
    checkOutput("vcoin_disp", 32'(dispense), 32'h1);
    applyStimulus(1, 8'd10, 0, 0, 0);
    checkOutput("vcoin_reject", 32'(coin_reject), 1);
    checkOutput("vcoin_change", 32'(change), 10);
    tick();
    checkOutput("vcoin_total", 32'(total_coin), 0);

    // Drink 4 from credit 40 leaves 15
    applyStimulus(1, 8'd40, 0, 0, 0);
    applyStimulus(0, 0, 1, 3'd4, 0);
    checkOutput("buy4_disp", 32'(dispense), 32'h8);
    checkOutput("buy4_total", 32'(total_coin), 15);
    tick();
`ifdef VEND_KEEP_CREDIT_EN
    checkOutput("keep_cv", 32'(change_valid), 0);
    checkOutput("keep_total", 32'(total_coin), 15);
    checkOutput("keep_busy", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("keep_cancel", 32'(change), 15);
    tick();
`else
    checkOutput("buy4_cv", 32'(change_valid), 1);
    checkOutput("buy4_change", 32'(change), 15);
    tick();
`endif
    checkOutput("buy4_idle", 32'(total_coin), 0);

    // Async reset in the middle of VEND
    applyStimulus(1, 8'd20, 0, 0, 0);
    applyStimulus(0, 0, 1, 3'd1, 0);
    checkOutput("arst_pre_dv", 32'(dispense_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_flags", {busy, dispense_valid, change_valid}, 0);
    checkOutput("arst_total", 32'(total_coin), 0);
    checkOutput("arst_disp", 32'(dispense), 0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("arst_after", {change_valid, dispense_valid, busy}, 0);
    checkOutput("arst_after_total", 32'(total_coin), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
